mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch requester and its data load/store requester.
- Sequences each access through a request/ready handshake to the memory and returns a one-cycle acknowledge to the winning requester.
- Sits between Core and a unified memory of MEM_SIZE words.
- Arbitration is data-priority, with a starvation guard for instruction fetch.

Parameters:
- MEM_WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 32, address width in bits.
- STARVE_LIMIT, 4, max consecutive data grants while instr_req is pending before instruction fetch is forced; range 1..15.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_req  in  1  instruction read request; held with instr_addr until instr_ack.
- instr_addr  in  ADDR_WIDTH  instruction fetch address.
- instr_rdata  out  MEM_WIDTH  fetched word; valid when instr_ack=1, held until the next instr_ack.
- instr_ack  out  1  one-cycle completion pulse for instruction port.
- data_req  in  1  data access request; held with data_we, data_addr and data_wdata until data_ack.
- data_we  in  1  1 = write, 0 = read.
- data_addr  in  ADDR_WIDTH  data address.
- data_wdata  in  MEM_WIDTH  store data.
- data_rdata  out  MEM_WIDTH  load data; valid when data_ack=1 after a read, held otherwise.
- data_ack  out  1  one-cycle completion pulse for data port.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_read_en  out  1  memory read command.
- mem_write_en  out  1  memory write command.
- mem_write_val  out  MEM_WIDTH  memory write data.
- mem_read_val  in  MEM_WIDTH  memory read data; sampled when mem_ready=1.
- mem_ready  in  1  memory completion; may be high in the first command cycle.
- busy  out  1  high in ACCESS and RESP states.

Behaviour:
- Reset (reset=0, asynchronous):
  - state := IDLE; starvation counter := 0.
  - All outputs := 0, including instr_rdata and data_rdata.
  - An access in flight is abandoned with no ack.
  - Normal operation resumes on the first clk edge after reset returns high.
- State machine: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - No request pending: stay in IDLE.
  - Otherwise choose a winner and go to ACCESS, registering mem_addr, mem_read_en/mem_write_en and mem_write_val from the winner.
  - Command outputs become visible in the next cycle.
- ACCESS:
  - Hold the command stable while mem_ready=0.
  - When mem_ready=1: capture mem_read_val into the winner's rdata (reads only; writes leave data_rdata unchanged), clear mem_read_en/mem_write_en, go to RESP.
- RESP:
  - The winner's ack is 1 for exactly this cycle; then go to IDLE.
  - A request still asserted in IDLE is treated as a new request.
- Arbitration rules:
  - Only data_req=1: data wins.
  - Only instr_req=1: instr wins.
  - Both asserted: data wins unless starvation counter == STARVE_LIMIT, in which case instr wins.
- Starvation counter (4 bits):
  - Increments on each data grant made while instr_req=1.
  - Clears on any instr grant, and in any IDLE cycle with instr_req=0.
  - Saturates at STARVE_LIMIT.
- Latency:
  - Request seen in IDLE at cycle t: command at t+1; ack at t+1+k+1, where k = cycles until mem_ready.
  - Minimum latency is 2 cycles, minimum issue interval 3 cycles.
- Boundary conditions:
  - mem_ready=1 in IDLE or RESP is ignored.
  - A req deasserted mid-access is a protocol violation; the access still completes and ack is still issued.
  - mem_read_en and mem_write_en are never both 1.
  - A 0-wait-state memory (mem_ready tied to 1) must work.

Test Plan:
- mem_ready tied to 1; instr_req=1, instr_addr=0x40, mem_read_val=0x2402000A -> mem_read_en=1 with mem_addr=0x40 at t+1; instr_ack=1 with instr_rdata=0x2402000A at t+2; exactly one ack pulse.
- data write: data_we=1, addr=0x80, wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_write_en/mem_addr/mem_write_val stable for 4 cycles; data_ack the cycle after mem_ready; data_rdata unchanged.
- instr_req and data_req asserted together from idle -> data granted first; instr granted in the next IDLE; data_ack precedes instr_ack by 3 cycles with 0 wait states.
- STARVE_LIMIT=4; data_req and instr_req held high continuously -> grant sequence D,D,D,D,I,D,D,D,D,I; starvation counter reads 0 after each I grant.
- reset pulled low during ACCESS with mem_ready=0 -> all outputs 0 immediately (asynchronous); no ack after release; next request behaves as from IDLE.
- back-to-back instr reads at 0x0, 0x4, 0x8 with req held high -> acks exactly 3 cycles apart with correct rdata for each address.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data load/store.
// Data has priority, but instruction fetch is forced after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int unsigned MEM_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_req,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic [MEM_WIDTH-1:0]  instr_rdata,
  output logic                  instr_ack,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [MEM_WIDTH-1:0]  data_wdata,
  output logic [MEM_WIDTH-1:0]  data_rdata,
  output logic                  data_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [MEM_WIDTH-1:0]  mem_write_val,
  input  logic [MEM_WIDTH-1:0]  mem_read_val,
  input  logic                  mem_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                state, state_nx;
  logic [3:0]            starve_cnt, starve_cnt_nx;
  logic                  grant_instr, grant_instr_nx;
  logic [ADDR_WIDTH-1:0] mem_addr_nx;
  logic                  mem_read_en_nx, mem_write_en_nx;
  logic [MEM_WIDTH-1:0]  mem_write_val_nx;
  logic [MEM_WIDTH-1:0]  instr_rdata_nx, data_rdata_nx;
  logic                  instr_ack_nx, data_ack_nx, busy_nx;

  always_comb begin
    state_nx         = state;
    starve_cnt_nx    = starve_cnt;
    grant_instr_nx   = grant_instr;
    mem_addr_nx      = mem_addr;
    mem_read_en_nx   = mem_read_en;
    mem_write_en_nx  = mem_write_en;
    mem_write_val_nx = mem_write_val;
    instr_rdata_nx   = instr_rdata;
    data_rdata_nx    = data_rdata;
    instr_ack_nx     = 1'b0;
    data_ack_nx      = 1'b0;

    unique case (state)
      IDLE: begin
        if (!instr_req) starve_cnt_nx = '0;
        if (instr_req || data_req) begin
          state_nx       = ACCESS;
          grant_instr_nx = instr_req && (!data_req || starve_cnt == LIMIT);
          if (grant_instr_nx) begin
            starve_cnt_nx    = '0;
            mem_addr_nx      = instr_addr;
            mem_read_en_nx   = 1'b1;
            mem_write_en_nx  = 1'b0;
            mem_write_val_nx = '0;
          end else begin
            // Only data grants that actually made a fetch wait count toward starvation.
            if (instr_req && starve_cnt < LIMIT) starve_cnt_nx = starve_cnt + 4'd1;
            mem_addr_nx      = data_addr;
            mem_read_en_nx   = !data_we;
            mem_write_en_nx  = data_we;
            mem_write_val_nx = data_wdata;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_nx        = RESP;
          mem_read_en_nx  = 1'b0;
          mem_write_en_nx = 1'b0;
          if (grant_instr) begin
            instr_rdata_nx = mem_read_val;
            instr_ack_nx   = 1'b1;
          end else begin
            if (mem_read_en) data_rdata_nx = mem_read_val;
            data_ack_nx = 1'b1;
          end
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      grant_instr   <= 1'b0;
      mem_addr      <= '0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      mem_write_val <= '0;
      instr_rdata   <= '0;
      data_rdata    <= '0;
      instr_ack     <= 1'b0;
      data_ack      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      starve_cnt    <= starve_cnt_nx;
      grant_instr   <= grant_instr_nx;
      mem_addr      <= mem_addr_nx;
      mem_read_en   <= mem_read_en_nx;
      mem_write_en  <= mem_write_en_nx;
      mem_write_val <= mem_write_val_nx;
      instr_rdata   <= instr_rdata_nx;
      data_rdata    <= data_rdata_nx;
      instr_ack     <= instr_ack_nx;
      data_ack      <= data_ack_nx;
      busy          <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int unsigned MW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic [MW-1:0] instr_rdata;
  logic          instr_ack;
  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [MW-1:0] data_wdata;
  logic [MW-1:0] data_rdata;
  logic          data_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [MW-1:0] mem_write_val;
  logic [MW-1:0] mem_read_val;
  logic          mem_ready;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instr_ack(instr_ack),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ack(data_ack),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_val(mem_write_val), .mem_read_val(mem_read_val), .mem_ready(mem_ready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] phys [64];
  logic [31:0] ref_mem [64];
  bit auto_mem = 1'b0;

  task automatic tick();
    @(negedge clk);
    if (auto_mem) mem_read_val = phys[mem_addr[7:2]];
  endtask

  task automatic clear_inputs();
    instr_req = 1'b0; instr_addr = '0; data_req = 1'b0; data_we = 1'b0;
    data_addr = '0; data_wdata = '0; mem_read_val = '0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, wdata, rval;
    logic        e_re, e_we;
    logic [31:0] e_addr;
    logic        e_iack, e_dack;
    logic [31:0] e_irdata, e_drdata;
  } vec_t;

  vec_t vec [5];

  // Reference model state
  bit          m_act, m_resp, m_cur_instr, m_we, m_re_o, m_we_o, m_iack, m_dack;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  int          m_starve;

  task automatic model_step(input bit ireq, input bit dreq, input bit dwe, input logic [31:0] iaddr,
                            input logic [31:0] daddr, input logic [31:0] dwdata, input bit rdy);
    m_iack = 1'b0; m_dack = 1'b0;
    if (m_resp) m_resp = 1'b0;
    else if (m_act) begin
      if (rdy) begin
        m_act = 1'b0; m_resp = 1'b1; m_re_o = 1'b0; m_we_o = 1'b0;
        if (m_cur_instr) begin m_irdata = ref_mem[m_addr[7:2]]; m_iack = 1'b1; end
        else begin
          if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
          else m_drdata = ref_mem[m_addr[7:2]];
          m_dack = 1'b1;
        end
      end
    end else begin
      if (!ireq) m_starve = 0;
      if (ireq || dreq) begin
        m_cur_instr = ireq && (!dreq || m_starve == int'(LIM));
        if (m_cur_instr) m_starve = 0;
        else if (ireq && m_starve < int'(LIM)) m_starve++;
        m_act  = 1'b1;
        m_we   = !m_cur_instr && dwe;
        m_addr = m_cur_instr ? iaddr : daddr;
        m_wdata = dwdata;
        m_re_o = !m_we;
        m_we_o = m_we;
      end
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  initial begin
    int dcyc, icyc, ngr, last, n;
    logic [31:0] held, ea;
    string grants;

    vec[0] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,   32'h0,        32'h2402000A,
               1'b1, 1'b0, 32'h40,  1'b1, 1'b0, 32'h2402000A, 32'h0};
    vec[1] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h84,  32'h0,        32'h11112222,
               1'b1, 1'b0, 32'h84,  1'b0, 1'b1, 32'h2402000A, 32'h11112222};
    vec[2] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h88,  32'hCAFEF00D, 32'h55555555,
               1'b0, 1'b1, 32'h88,  1'b0, 1'b1, 32'h2402000A, 32'h11112222};
    vec[3] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 32'h0,        32'h0BADF00D,
               1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h2402000A, 32'h0BADF00D};
    vec[4] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'h0,   32'h0,        32'h13572468,
               1'b1, 1'b0, 32'h44,  1'b1, 1'b0, 32'h13572468, 32'h0BADF00D};

    for (int i = 0; i < 64; i++) phys[i] = 32'hC0DE0000 | 32'(i);

    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ren", 32'(mem_read_en), 0);
    chk("rst_wen", 32'(mem_write_en), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_irdata", instr_rdata, 0);
    chk("rst_drdata", data_rdata, 0);
    chk("rst_acks", {30'b0, instr_ack, data_ack}, 0);

    // Directed vectors, zero wait states, each from idle
    for (int v = 0; v < 5; v++) begin
      instr_req = vec[v].ireq; data_req = vec[v].dreq; data_we = vec[v].dwe;
      instr_addr = vec[v].iaddr; data_addr = vec[v].daddr; data_wdata = vec[v].wdata;
      mem_read_val = vec[v].rval; mem_ready = 1'b1;
      tick();
      chk("vec_ren", 32'(mem_read_en), 32'(vec[v].e_re));
      chk("vec_wen", 32'(mem_write_en), 32'(vec[v].e_we));
      chk("vec_addr", mem_addr, vec[v].e_addr);
      if (vec[v].e_we) chk("vec_wval", mem_write_val, vec[v].wdata);
      chk("vec_busy1", 32'(busy), 1);
      chk("vec_noack_early", {30'b0, instr_ack, data_ack}, 0);
      tick();
      chk("vec_iack", 32'(instr_ack), 32'(vec[v].e_iack));
      chk("vec_dack", 32'(data_ack), 32'(vec[v].e_dack));
      chk("vec_irdata", instr_rdata, vec[v].e_irdata);
      chk("vec_drdata", data_rdata, vec[v].e_drdata);
      chk("vec_en_clr", {30'b0, mem_read_en, mem_write_en}, 0);
      instr_req = 1'b0; data_req = 1'b0;
      tick();
      chk("vec_one_pulse", {30'b0, instr_ack, data_ack}, 0);
      chk("vec_busy0", 32'(busy), 0);
    end

    // Data write with three wait states
    held = data_rdata;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h80; data_wdata = 32'hDEADBEEF; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_wen", 32'(mem_write_en), 1);
      chk("wr_ren", 32'(mem_read_en), 0);
      chk("wr_addr", mem_addr, 32'h80);
      chk("wr_wval", mem_write_val, 32'hDEADBEEF);
      chk("wr_noack", 32'(data_ack), 0);
      if (i == 3) mem_ready = 1'b1;
    end
    tick();
    chk("wr_dack", 32'(data_ack), 1);
    chk("wr_wen_clr", 32'(mem_write_en), 0);
    chk("wr_drdata_held", data_rdata, held);
    data_req = 1'b0; data_we = 1'b0;
    tick();

    // Simultaneous requests: data first, instr three cycles later
    instr_req = 1'b1; instr_addr = 32'h48; data_req = 1'b1; data_addr = 32'h90; mem_ready = 1'b1;
    dcyc = -1; icyc = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (data_ack) begin dcyc = c; data_req = 1'b0; end
      if (instr_ack) begin icyc = c; instr_req = 1'b0; end
    end
    chk("both_dack_cycle", 32'(dcyc), 2);
    chk("both_iack_cycle", 32'(icyc), 5);

    // Starvation guard with both requests held continuously
    instr_req = 1'b1; data_req = 1'b1; data_we = 1'b0; mem_ready = 1'b1;
    grants = ""; ngr = 0;
    for (int c = 0; c < 40 && ngr < 10; c++) begin
      tick();
      if (data_ack) begin grants = {grants, "D"}; ngr++; end
      if (instr_ack) begin
        grants = {grants, "I"}; ngr++;
        chk("starve_cnt_after_i", 32'(dut.starve_cnt), 0);
      end
    end
    instr_req = 1'b0; data_req = 1'b0;
    checks++;
    if (grants != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL starve_seq: got %s expected DDDDIDDDDI", grants);
    end
    repeat (2) tick();

    // Asynchronous reset during an access
    instr_req = 1'b1; instr_addr = 32'h60; mem_ready = 1'b0; mem_read_val = 32'h99;
    tick();
    chk("rsta_ren_pre", 32'(mem_read_en), 1);
    #1 reset = 1'b0;
    #1;
    chk("rsta_ren", 32'(mem_read_en), 0);
    chk("rsta_addr", mem_addr, 0);
    chk("rsta_busy", 32'(busy), 0);
    chk("rsta_irdata", instr_rdata, 0);
    chk("rsta_drdata", data_rdata, 0);
    tick();
    instr_req = 1'b0; mem_ready = 1'b1; reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rsta_no_ack", {30'b0, instr_ack, data_ack}, 0);
      chk("rsta_idle", 32'(busy), 0);
    end
    instr_req = 1'b1; instr_addr = 32'h64; mem_read_val = 32'h77;
    tick();
    chk("rsta_new_ren", 32'(mem_read_en), 1);
    chk("rsta_new_addr", mem_addr, 32'h64);
    tick();
    chk("rsta_new_iack", 32'(instr_ack), 1);
    chk("rsta_new_irdata", instr_rdata, 32'h77);
    instr_req = 1'b0;
    tick();

    // Back-to-back instruction reads from the memory array
    auto_mem = 1'b1; mem_ready = 1'b1;
    instr_req = 1'b1; instr_addr = 32'h0; n = 0; last = 0;
    for (int c = 1; c <= 20 && n < 3; c++) begin
      tick();
      if (instr_ack) begin
        ea = 32'hC0DE0000 | (instr_addr >> 2);
        chk("b2b_rdata", instr_rdata, ea);
        if (n > 0) chk("b2b_interval", 32'(c - last), 3);
        last = c; n++;
        if (n == 3) instr_req = 1'b0;
        else instr_addr = instr_addr + 32'd4;
      end
    end
    chk("b2b_count", 32'(n), 3);
    tick();

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = phys[i];
    m_act = 0; m_resp = 0; m_cur_instr = 0; m_we = 0; m_re_o = 0; m_we_o = 0;
    m_iack = 0; m_dack = 0; m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0; m_starve = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      chk("rnd_busy", 32'(busy), 32'(m_act || m_resp));
      chk("rnd_ren", 32'(mem_read_en), 32'(m_re_o));
      chk("rnd_wen", 32'(mem_write_en), 32'(m_we_o));
      chk("rnd_excl", 32'(mem_read_en & mem_write_en), 0);
      if (m_re_o || m_we_o) chk("rnd_addr", mem_addr, m_addr);
      if (m_we_o) chk("rnd_wval", mem_write_val, m_wdata);
      chk("rnd_iack", 32'(instr_ack), 32'(m_iack));
      chk("rnd_dack", 32'(data_ack), 32'(m_dack));
      chk("rnd_irdata", instr_rdata, m_irdata);
      chk("rnd_drdata", data_rdata, m_drdata);

      if (m_iack) begin
        if ($urandom_range(0, 1) == 1) instr_addr = rnd_addr();
        else instr_req = 1'b0;
      end
      if (m_dack) begin
        if ($urandom_range(0, 1) == 1) begin
          data_we = 1'($urandom_range(0, 1)); data_addr = rnd_addr(); data_wdata = $urandom;
        end else data_req = 1'b0;
      end
      if (!instr_req && $urandom_range(0, 3) == 0) begin
        instr_req = 1'b1; instr_addr = rnd_addr();
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req = 1'b1; data_we = 1'($urandom_range(0, 1)); data_addr = rnd_addr(); data_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      if (mem_write_en && mem_ready) phys[mem_addr[7:2]] = mem_write_val;
      model_step(instr_req, data_req, data_we, instr_addr, data_addr, data_wdata, mem_ready);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
